// File: rtl/sdram_clk_rst_seq.sv
// sdram_clk_rst_seq: power-up and lock supervisor for the SDRAM clock PLL.
//
// Runs on the 27 MHz board reference clock, which also feeds the PLL, so it
// keeps running while the PLL is unlocked. Pulses the PLL reset and waits
// for lock. Lock must hold for a settle window, then the SDRAM power-up wait
// must elapse. Only then is the SDRAM controller released from reset.
// Lock loss re-runs the sequence.
//
// Ports:
//   refclk        in   sole clock (27 MHz reference)
//   rst           in   synchronous active-high reset
//   locked        in   PLL lock flag, asynchronous to refclk
//   pll_rst       out  PLL reset request, active-high
//   ctrl_rst      out  SDRAM controller reset, active-high; the consumer
//                      re-synchronises it into its own domain
//   sdram_ready   out  high only in RUN
//   state         out  current FSM state code (0..4)
//   relock_count  out  saturating count of lock-loss events in RUN
//
// Optional feature: define SDRAM_RELOCK_CNT_EN to build the relock counter.
// Without it, relock_count is tied to zero.
module sdram_clk_rst_seq #(
    parameter int unsigned PLL_RST_CYCLES = 32,
    parameter int unsigned LOCK_TIMEOUT   = 27000,
    parameter int unsigned STABLE_CYCLES  = 1024,
    parameter int unsigned PWRUP_CYCLES   = 5400,
    parameter int unsigned LOSS_FILTER    = 4
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       locked,
    output logic       pll_rst,
    output logic       ctrl_rst,
    output logic       sdram_ready,
    output logic [2:0] state,
    output logic [7:0] relock_count
);

    typedef enum logic [2:0] {
        StPllRst   = 3'd0,
        StWaitLock = 3'd1,
        StStable   = 3'd2,
        StPwrup    = 3'd3,
        StRun      = 3'd4
    } state_e;

    localparam logic [15:0] PllRstLast  = 16'(PLL_RST_CYCLES - 1);
    localparam logic [15:0] TimeoutLast = 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] StableLast  = 16'(STABLE_CYCLES - 1);
    localparam logic [15:0] PwrupLast   = 16'(PWRUP_CYCLES - 1);
    localparam logic [15:0] LossLast    = 16'(LOSS_FILTER - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        sync1_q, locked_s_q;
    logic        pll_rst_q, ctrl_rst_q, ready_q;

    // In RUN the cycle counter doubles as the lock-loss filter: it counts
    // consecutive unlocked cycles and is cleared by any locked cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        case (state_q)
            StPllRst: begin
                if (cnt_q == PllRstLast) state_d = StWaitLock;
            end
            StWaitLock: begin
                if (locked_s_q)                state_d = StStable;
                else if (cnt_q == TimeoutLast) state_d = StPllRst;
            end
            StStable: begin
                if (!locked_s_q)              state_d = StWaitLock;
                else if (cnt_q == StableLast) state_d = StPwrup;
            end
            StPwrup: begin
                if (!locked_s_q)             state_d = StPllRst;
                else if (cnt_q == PwrupLast) state_d = StRun;
            end
            StRun: begin
                if (locked_s_q)             cnt_d   = '0;
                else if (cnt_q == LossLast) state_d = StPllRst;
            end
            default: state_d = StPllRst;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    // Outputs are decoded from next-state so they move on the same edge as state.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q    <= StPllRst;
            cnt_q      <= '0;
            sync1_q    <= 1'b0;
            locked_s_q <= 1'b0;
            pll_rst_q  <= 1'b1;
            ctrl_rst_q <= 1'b1;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sync1_q    <= locked;
            locked_s_q <= sync1_q;
            pll_rst_q  <= (state_d == StPllRst);
            ctrl_rst_q <= (state_d != StRun);
            ready_q    <= (state_d == StRun);
        end
    end

    assign state       = state_q;
    assign pll_rst     = pll_rst_q;
    assign ctrl_rst    = ctrl_rst_q;
    assign sdram_ready = ready_q;

`ifdef SDRAM_RELOCK_CNT_EN
    logic [7:0] relock_q, relock_d;

    // Only RUN -> PLLRST is a lock-loss event; timeouts never leave RUN.
    always_comb begin
        relock_d = relock_q;
        if (state_q == StRun && state_d == StPllRst && relock_q != 8'hff) begin
            relock_d = relock_q + 8'd1;
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) relock_q <= '0;
        else     relock_q <= relock_d;
    end

    assign relock_count = relock_q;
`else
    assign relock_count = 8'd0;
`endif

endmodule
